// File: rtl/conv_uart_pkg.sv
// Shared constants, kernel and FSM encoding for the conv_uart convolution engine.
package conv_uart_pkg;

  localparam int KSIZE  = 7;
  localparam int NTAPS  = KSIZE * KSIZE;
  localparam int K_BITS = 8;

  // Fixed kernel, row-major; all ones gives a 49-tap box filter.
  localparam logic [K_BITS-1:0] KERNEL [0:NTAPS-1] = '{default: 8'd1};

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    SEND,
    WAIT
  } state_t;

  // Accumulator wide enough for 49 full-scale pixel*coefficient products.
  function automatic int acc_width(input int d_bits);
    return 2 * d_bits + 6;
  endfunction

endpackage

// File: rtl/conv_uart_img_ram.sv
// Single-port synchronous image RAM with one cycle of read latency.
module conv_uart_img_ram
  import conv_uart_pkg::*;
#(
  parameter int DEPTH = 81,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Write when enabled; the read port always returns the addressed word one cycle later.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/conv_uart.sv
// Frame-buffered 7x7 convolution: load a full image, then emit one saturated
// result byte per output position, paced BYTE_GAP cycles apart.
module conv_uart
  import conv_uart_pkg::*;
#(
  parameter int row_depth    = 9,
  parameter int column_depth = 9,
  parameter int D_BITS       = 8,
  parameter int BYTE_GAP     = 1200,
  parameter int SHIFT        = 6
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [D_BITS-1:0] i_data,
  input  logic              i_drdy,
  output logic [D_BITS-1:0] o_data,
  output logic              o_dvalid
);

  localparam int TOTPIX = row_depth * column_depth;
  localparam int AW     = $clog2(TOTPIX);
  localparam int ACC_W  = acc_width(D_BITS);
  localparam int PW     = 2 * D_BITS;
  localparam int RW     = $clog2(row_depth);
  localparam int CW     = $clog2(column_depth);
  localparam int GW     = $clog2(BYTE_GAP + 1);
  localparam int TW     = $clog2(NTAPS + 2);
  localparam int KW     = $clog2(KSIZE);

  localparam logic [AW-1:0]    LAST_ADDR = AW'(TOTPIX - 1);
  localparam logic [RW-1:0]    LAST_R    = RW'(row_depth - KSIZE);
  localparam logic [CW-1:0]    LAST_C    = CW'(column_depth - KSIZE);
  localparam logic [TW-1:0]    TAP_N     = TW'(NTAPS);
  localparam logic [TW-1:0]    TAP_END   = TW'(NTAPS + 1);
  localparam logic [KW-1:0]    K_LAST    = KW'(KSIZE - 1);
  localparam logic [GW-1:0]    GAP_GO    = GW'(BYTE_GAP - 2);
  localparam logic [ACC_W-1:0] MAXV      = ACC_W'((1 << D_BITS) - 1);

  state_t state, state_nxt;

  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [D_BITS-1:0] ram_q;
  logic [RW-1:0]     pos_r;
  logic [CW-1:0]     pos_c;
  logic [KW-1:0]     ki;
  logic [KW-1:0]     kj;
  logic [TW-1:0]     tap;
  logic [TW-1:0]     kidx;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_shift;
  logic [PW-1:0]     prod;
  logic [GW-1:0]     gap_cnt;
  logic              first_pos;
  logic              last_pos;
  logic              mac_done;

  conv_uart_img_ram #(
    .DEPTH (TOTPIX),
    .WIDTH (D_BITS),
    .AW    (AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (i_data),
    .rdata (ram_q)
  );

  assign first_pos = (pos_r == '0) && (pos_c == '0);
  assign last_pos  = (pos_r == LAST_R) && (pos_c == LAST_C);
  assign mac_done  = (tap == TAP_END);
  assign acc_shift = acc >> SHIFT;

  // Read address of the current tap and the product of the word that arrived for the previous tap.
  always_comb begin
    rd_addr = AW'((int'(pos_r) + int'(ki)) * column_depth + int'(pos_c) + int'(kj));
    kidx    = '0;
    if (tap != '0 && tap <= TAP_N) begin
      kidx = tap - TW'(1);
    end
    prod = PW'(ram_q) * PW'(KERNEL[kidx]);
  end

  // State register.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and RAM port steering; the RAM belongs to the loader only in LOAD.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = rd_addr;
    case (state)
      LOAD: begin
        ram_addr = wr_addr;
        ram_we   = i_drdy;
        if (i_drdy && wr_addr == LAST_ADDR) begin
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        if (mac_done) begin
          state_nxt = (first_pos || gap_cnt >= GAP_GO) ? SEND : WAIT;
        end
      end
      WAIT: begin
        if (gap_cnt >= GAP_GO) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        state_nxt = last_pos ? LOAD : COMPUTE;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  // Raster write pointer; wraps to zero on the last pixel of a frame.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      wr_addr <= '0;
    end else if (state == LOAD && i_drdy) begin
      wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + AW'(1);
    end
  end

  // Sequential MAC: issue one tap address per cycle, accumulate the returned word a cycle later.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      tap <= '0;
      ki  <= '0;
      kj  <= '0;
      acc <= '0;
    end else begin
      case (state)
        COMPUTE: begin
          if (tap != TAP_END) begin
            tap <= tap + TW'(1);
          end
          if (tap < TAP_N) begin
            if (kj == K_LAST) begin
              kj <= '0;
              ki <= (ki == K_LAST) ? '0 : ki + KW'(1);
            end else begin
              kj <= kj + KW'(1);
            end
          end
          if (tap != '0 && tap <= TAP_N) begin
            acc <= acc + ACC_W'(prod);
          end
        end
        WAIT: begin
        end
        default: begin
          tap <= '0;
          ki  <= '0;
          kj  <= '0;
          acc <= '0;
        end
      endcase
    end
  end

  // Emit the saturated result, then step to the next output position in raster order.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      o_data   <= '0;
      o_dvalid <= 1'b0;
      pos_r    <= '0;
      pos_c    <= '0;
    end else begin
      o_dvalid <= 1'b0;
      if (state == SEND) begin
        o_dvalid <= 1'b1;
        o_data   <= (acc_shift > MAXV) ? {D_BITS{1'b1}} : acc_shift[D_BITS-1:0];
        if (last_pos) begin
          pos_r <= '0;
          pos_c <= '0;
        end else if (pos_c == LAST_C) begin
          pos_c <= '0;
          pos_r <= pos_r + RW'(1);
        end else begin
          pos_c <= pos_c + CW'(1);
        end
      end else if (state == LOAD) begin
        pos_r <= '0;
        pos_c <= '0;
      end
    end
  end

  // Cycles since the last emitted byte; saturates once the next byte is due.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (state == SEND) begin
      gap_cnt <= '0;
    end else if ((state == COMPUTE || state == WAIT) && gap_cnt < GAP_GO) begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

endmodule

// File: tb/tb_conv_uart.sv
// Self-checking bench for conv_uart: a frame-level model predicts every result
// byte and its emission cycle; a negedge monitor compares the DUT against it.
module tb_conv_uart;
  import conv_uart_pkg::*;

  localparam int ROWS = 9;
  localparam int COLS = 9;
  localparam int DB   = 8;
  localparam int GAP  = 60;
  localparam int SH   = 6;
  localparam int NPIX = ROWS * COLS;
  localparam int NOUT = (ROWS - 6) * (COLS - 6);
  localparam int FIRST_LAT = 52;

  logic          i_clk = 1'b0;
  logic          reset;
  logic [DB-1:0] i_data;
  logic          i_drdy;
  logic [DB-1:0] o_data;
  logic          o_dvalid;

  conv_uart #(
    .row_depth    (ROWS),
    .column_depth (COLS),
    .D_BITS       (DB),
    .BYTE_GAP     (GAP),
    .SHIFT        (SH)
  ) dut (
    .i_clk    (i_clk),
    .reset    (reset),
    .i_data   (i_data),
    .i_drdy   (i_drdy),
    .o_data   (o_data),
    .o_dvalid (o_dvalid)
  );

  // 10-time-unit clock.
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int img [NPIX];
  int exp_q [$];
  int got_q [$];
  int frame_left = 0;
  int last_pix_cyc = 0;
  int prev_cyc = 0;
  int hold_val = 0;

  // Rising-edge counter used to time-stamp strobes and output pulses.
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Valid-region convolution of the model image at one output position.
  function automatic int model_out(input int r, input int c);
    int sum;
    sum = 0;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++)
        sum += img[(r + i) * COLS + (c + j)] * int'(KERNEL[i * 7 + j]);
    sum = sum / (1 << SH);
    if (sum > 255) sum = 255;
    return sum;
  endfunction

  // kind: 0 = all 64, 1 = all 255, 2 = ramp. Sends npix pixels with gap idle
  // cycles between strobes, then 'extra' ignored 255-strobes during output.
  task automatic applyStimulus(input int kind, input int gap, input int npix, input int extra);
    for (int p = 0; p < NPIX; p++)
      img[p] = (kind == 0) ? 64 : (kind == 1) ? 255 : p;
    got_q.delete();
    for (int p = 0; p < npix; p++) begin
      i_drdy = 1'b1;
      i_data = DB'(img[p]);
      @(posedge i_clk);
      #1;
      i_drdy = 1'b0;
      if (p == NPIX - 1) begin
        last_pix_cyc = cyc;
        for (int r = 0; r < ROWS - 6; r++)
          for (int c = 0; c < COLS - 6; c++)
            exp_q.push_back(model_out(r, c));
        frame_left = NOUT;
      end
      repeat (gap) begin
        @(posedge i_clk);
        #1;
      end
    end
    for (int k = 0; k < extra; k++) begin
      i_drdy = 1'b1;
      i_data = 8'hFF;
      @(posedge i_clk);
      #1;
      i_drdy = 1'b0;
      repeat (25) begin
        @(posedge i_clk);
        #1;
      end
    end
  endtask

  // Bounded wait for every expected byte of the current frame.
  task automatic waitFrame();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < NOUT * GAP + 300) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checkOutput("frame_done_pending", exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      frame_left = 0;
    end
    checkOutput("pulse_count", got_q.size(), NOUT);
    repeat (3) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Compare process: reset values, each pulse's data and cycle, and o_data hold between pulses.
  always @(negedge i_clk) begin : monitor
    int expv;
    int expc;
    if (reset) begin
      checkOutput("reset_dvalid", int'(o_dvalid), 0);
      checkOutput("reset_data", int'(o_data), 0);
      hold_val = 0;
    end else if (o_dvalid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pulse", 1, 0);
      end else begin
        expv = exp_q.pop_front();
        expc = (frame_left == NOUT) ? last_pix_cyc + FIRST_LAT : prev_cyc + GAP;
        checkOutput("result_data", int'(o_data), expv);
        checkOutput("result_cycle", cyc, expc);
        prev_cyc = cyc;
        frame_left--;
        got_q.push_back(int'(o_data));
        hold_val = expv;
      end
    end else begin
      checkOutput("data_hold", int'(o_data), hold_val);
    end
  end

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    i_drdy = 1'b0;
    i_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    reset = 1'b0;

    $display("[TB] frame: constant 64");
    applyStimulus(0, 0, NPIX, 0);
    checkOutput("model_const64", exp_q[0], 49);
    waitFrame();
    checkOutput("const64_first", got_q[0], 49);
    checkOutput("const64_last", got_q[NOUT-1], 49);

    $display("[TB] frame: constant 255");
    applyStimulus(1, 1, NPIX, 0);
    checkOutput("model_const255", exp_q[0], 195);
    waitFrame();
    checkOutput("const255_mid", got_q[4], 195);

    $display("[TB] frame: ramp");
    applyStimulus(2, 0, NPIX, 0);
    checkOutput("model_ramp_00", exp_q[0], 22);
    checkOutput("model_ramp_22", exp_q[NOUT-1], 38);
    waitFrame();
    checkOutput("ramp_out_00", got_q[0], 22);
    checkOutput("ramp_out_22", got_q[NOUT-1], 38);

    $display("[TB] frame: slow strobes every GAP cycles");
    applyStimulus(0, GAP - 1, NPIX, 0);
    waitFrame();

    $display("[TB] frame: reset after 40 pixels, then full frame");
    applyStimulus(1, 0, 40, 0);
    reset = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    reset = 1'b0;
    @(posedge i_clk);
    #1;
    applyStimulus(0, 0, NPIX, 0);
    waitFrame();
    for (int k = 0; k < NOUT; k++)
      checkOutput("after_reset_val", got_q[k], 49);

    $display("[TB] frame: ignored strobes during output, then another frame");
    applyStimulus(0, 0, NPIX, 10);
    waitFrame();
    applyStimulus(0, 2, NPIX, 0);
    waitFrame();
    for (int k = 0; k < NOUT; k++)
      checkOutput("after_extra_val", got_q[k], 49);

    checkOutput("final_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
